inst_fetch_stage: RTL and testbench
===================================

// Module: inst_fetch_stage
// PURPOSE
//  Instruction-fetch front end of the openmips core: owns the fetch PC and issues word reads to the
//  instruction RAM over a req/ack port (one request outstanding, RAM may insert wait states).
//  Fetched {pc, inst} pairs go into a 2-entry buffer that feeds the ID stage through a valid/ready handshake.
//  Branch/jump redirects from ID/EX flush the buffer and restart fetch at the new PC.
// PARAMETERS
//  ADDR_W    32  width of PCs and memory addresses
//  DATA_W    32  instruction word width
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk             in   1       clock; all state changes on posedge
//  rst             in   1       reset, asynchronous, active-low
//  mem_req         out  1       read request to instruction RAM
//  mem_addr        out  ADDR_W  read address, word aligned; stable while mem_req=1 and not acked
//  mem_ack         in   1       RAM accepts the request and returns data this cycle
//  mem_rdata       in   DATA_W  instruction word, valid when mem_ack=1
//  redirect_valid  in   1       branch/jump taken; restart fetch at redirect_pc
//  redirect_pc     in   ADDR_W  new PC; bits [1:0] are ignored (forced to 0)
//  id_valid        out  1       buffer head is a valid instruction
//  id_ready        in   1       ID consumes the head this cycle
//  id_pc           out  ADDR_W  PC of the head instruction (0 when empty)
//  id_inst         out  DATA_W  head instruction word (0 when empty)
// BEHAVIOUR
//  - Reset (rst=0, async): mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, buffer empty, id_valid=0,
//    id_pc=0, id_inst=0, FSM=IDLE. The first request is raised on the first posedge after rst rises.
//  - Buffer: 2 entries, FIFO order; count in 0..2. id_valid=(count!=0). Pop when id_valid&id_ready.
//  - Space rule: a request is issued/kept only if count' + 1 <= 2, where count' is count after this
//    edge's push/pop. A push therefore never finds the buffer full; overflow is impossible by design.
//  - FSM states:
//    IDLE: mem_req=0. If there is space, next state is WAIT with mem_req=1 and mem_addr=fetch_pc.
//    WAIT: mem_req=1 and mem_addr held until mem_ack.
//      On ack: push {mem_addr, mem_rdata}; fetch_pc+=4 (wraps mod 2^ADDR_W).
//      If space remains, stay in WAIT with mem_addr=fetch_pc+4 (back-to-back, 1 word/cycle with
//      a zero-wait RAM); otherwise go to IDLE.
//    DROP: a request is still in flight after a redirect. mem_req/mem_addr stay held; on ack the
//      data is discarded, then go to WAIT at fetch_pc (if space) or IDLE.
//  - Redirect (highest priority, same-cycle pop and push are ignored):
//    flush buffer (count=0); fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
//    From IDLE: go to WAIT at the new PC.
//    From WAIT or DROP with mem_ack=1 that cycle: discard the data and go to WAIT at the new PC.
//    From WAIT or DROP without ack: go to DROP. mem_addr is not changed until ack; the
//    redirect target is applied only afterwards. A second redirect while in DROP overwrites fetch_pc.
//  - Latency: req raised at cycle N with ack in cycle N => id_valid=1 with that word in N+1.
//  - id_pc/id_inst reflect the head entry combinationally from the buffer registers. Outputs are
//    0 when the buffer is empty.
// TESTING
//  1 Reset: hold rst=0 for 10 cycles, then release -> while low, mem_req=0, id_valid=0,
//    mem_addr=0x0; first posedge after release gives mem_req=1 with mem_addr=0x0.
//  2 Zero-wait stream, RAM[i]=0x34010000+i, id_ready=1 -> id_pc 0x0,0x4,0x8,... on consecutive
//    cycles, id_inst 0x34010000,0x34010001,..., no bubbles after the first word.
//  3 Backpressure: id_ready=0 for 8 cycles -> exactly 2 words buffered (pc 0x0,0x4), mem_req=0,
//    no further requests; id_ready=1 -> 0x0,0x4,0x8 delivered in order, none lost or duplicated.
//  4 Redirect to 0x43 while a request to 0x8 is unacked (RAM acks after 3 waits) -> mem_addr stays
//    0x8 until ack, data dropped, id_valid=0 meanwhile; next request and first delivered id_pc=0x40.
//  5 redirect_valid coincident with mem_ack and id_ready -> acked word discarded, buffer empty next
//    cycle, next mem_addr=target.
//  6 Drop rst to 0 asynchronously mid-WAIT (between edges) -> mem_req and id_valid fall at once;
//    after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, issues single-outstanding word reads,
// and buffers up to two {pc, inst} pairs for ID. Redirects flush and restart fetch.
module inst_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t                 r_state, w_state_nx;
    logic [ADDR_W-1:0]      r_addr, w_addr_nx;
    logic [ADDR_W-1:0]      r_fetch_pc, w_fetch_pc_nx;
    logic [1:0][ADDR_W-1:0] r_buf_pc;
    logic [1:0][DATA_W-1:0] r_buf_inst;
    logic                   r_head;
    logic [1:0]             r_count;
    logic [1:0]             w_count_nx;
    logic                   w_pop, w_push, w_space, w_wr_idx;
    logic [ADDR_W-1:0]      w_target, w_pc_inc;

    assign w_target   = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_pc_inc   = r_fetch_pc + ADDR_W'(4);
    assign w_pop      = (r_count != 2'd0) && id_ready && !redirect_valid;
    assign w_push     = (r_state == S_WAIT) && mem_ack && !redirect_valid;
    assign w_count_nx = redirect_valid ? 2'd0 : r_count + {1'b0, w_push} - {1'b0, w_pop};
    // Room for one more word after this edge's push/pop, so a push never meets a full buffer.
    assign w_space    = (w_count_nx != 2'd2);
    assign w_wr_idx   = r_head ^ r_count[0];

    assign mem_req  = (r_state != S_IDLE);
    assign mem_addr = r_addr;
    assign id_valid = (r_count != 2'd0);
    assign id_pc    = id_valid ? r_buf_pc[r_head]   : '0;
    assign id_inst  = id_valid ? r_buf_inst[r_head] : '0;

    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_fetch_pc_nx = r_fetch_pc;
        unique case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_state_nx    = S_WAIT;
                    w_addr_nx     = w_target;
                    w_fetch_pc_nx = w_target;
                end else if (w_space) begin
                    w_state_nx = S_WAIT;
                    w_addr_nx  = r_fetch_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_fetch_pc_nx = w_target;
                    if (mem_ack) w_addr_nx  = w_target;
                    else         w_state_nx = S_DROP;
                end else if (mem_ack) begin
                    w_fetch_pc_nx = w_pc_inc;
                    if (w_space) w_addr_nx  = w_pc_inc;
                    else         w_state_nx = S_IDLE;
                end
            end
            S_DROP: begin
                // The in-flight address stays on the port until acked; its data is thrown away.
                if (redirect_valid) begin
                    w_fetch_pc_nx = w_target;
                    if (mem_ack) begin
                        w_state_nx = S_WAIT;
                        w_addr_nx  = w_target;
                    end
                end else if (mem_ack) begin
                    if (w_space) begin
                        w_state_nx = S_WAIT;
                        w_addr_nx  = r_fetch_pc;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_buf_pc   <= '0;
            r_buf_inst <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_fetch_pc <= w_fetch_pc_nx;
            r_count    <= w_count_nx;
            if (w_pop) r_head <= ~r_head;
            if (w_push) begin
                r_buf_pc[w_wr_idx]   <= r_addr;
                r_buf_inst[w_wr_idx] <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_stage.sv
// Randomized bench for inst_fetch_stage: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_inst_fetch_stage;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;

    int checks = 0;
    int failures = 0;

    inst_fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram(input logic [AW-1:0] a);
        return 32'h3401_0000 + (a >> 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM responder: per-request wait count, fixed or random.
    int  waits = 0;
    bit  rand_w = 0;
    initial begin
        int  cnt = 0;
        int  cur_w = 0;
        bit  prev_ack = 0;
        bit  prev_req = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (prev_ack || !prev_req) begin
                    cnt = 0;
                    cur_w = rand_w ? int'($urandom_range(0, 3)) : waits;
                end
                mem_ack = (cnt >= cur_w);
                cnt++;
            end else begin
                mem_ack = 1'b0;
            end
            mem_rdata = mem_ack ? ram(mem_addr) : $urandom;
            prev_ack = mem_ack;
            prev_req = mem_req;
        end
    end

    // Reference model: outstanding request + FIFO of delivered pairs.
    logic [63:0]   m_q[$];
    bit            m_inflight = 0;
    bit            m_drop = 0;
    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] m_fpc = '0;
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_inflight = 0; m_drop = 0; m_addr = '0; m_fpc = '0;
            end else begin
                bit ack;
                ack = m_inflight && mem_ack;
                if (redirect_valid) begin
                    m_q.delete();
                    m_fpc = {redirect_pc[AW-1:2], 2'b00};
                    if (!m_inflight || ack) begin
                        m_inflight = 1; m_drop = 0; m_addr = m_fpc;
                    end else begin
                        m_drop = 1;
                    end
                end else begin
                    if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
                    if (ack && !m_drop) begin
                        m_q.push_back({m_addr, mem_rdata});
                        m_fpc = m_fpc + 4;
                    end
                    if (ack) begin
                        m_inflight = 0; m_drop = 0;
                    end
                    if (!m_inflight && m_q.size() <= 1) begin
                        m_inflight = 1; m_addr = m_fpc;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_mem_req", 64'(mem_req), 64'(m_inflight));
            if (m_inflight || !rst) chk("cyc_mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("cyc_id_valid", 64'(id_valid), 64'(m_q.size() > 0));
            chk("cyc_id_pc", 64'(id_pc), m_q.size() > 0 ? 64'(m_q[0][63:32]) : 64'd0);
            chk("cyc_id_inst", 64'(id_inst), m_q.size() > 0 ? 64'(m_q[0][31:0]) : 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] got[$];
        int n;

        // Reset behaviour and first request.
        id_ready = 1'b1; waits = 0; rand_w = 0;
        repeat (10) begin
            @(negedge clk);
            chk("rst_mem_req", 64'(mem_req), 64'd0);
            chk("rst_id_valid", 64'(id_valid), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        end
        step();
        rst = 1'b1;
        step();
        chk("first_req", 64'(mem_req), 64'd1);
        chk("first_addr", 64'(mem_addr), 64'd0);

        // Zero-wait stream: one word per cycle, no bubbles.
        n = 0;
        while (!id_valid && n < 5) begin step(); n++; end
        for (int k = 0; k < 8; k++) begin
            chk("stream_valid", 64'(id_valid), 64'd1);
            chk("stream_pc", 64'(id_pc), 64'(4 * k));
            chk("stream_inst", 64'(id_inst), 64'(32'h3401_0000 + k));
            step();
        end

        // Backpressure: buffer fills with two words, fetch stops.
        id_ready = 1'b0;
        do_reset();
        repeat (8) step();
        chk("bp_mem_req", 64'(mem_req), 64'd0);
        chk("bp_id_valid", 64'(id_valid), 64'd1);
        chk("bp_head_pc", 64'(id_pc), 64'd0);
        chk("bp_head_inst", 64'(id_inst), 64'h3401_0000);
        id_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            if (id_valid) got.push_back(id_pc);
            step();
        end
        chk("bp_count", 64'(got.size() >= 3), 64'd1);
        for (int i = 0; i < 3; i++)
            chk("bp_order", got.size() > i ? 64'(got[i]) : 64'hDEAD, 64'(4 * i));

        // Redirect while a slow request is outstanding.
        waits = 3;
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 32'h8) && n < 40) begin step(); n++; end
        chk("drop_reached_8", 64'(mem_addr), 64'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        step();
        redirect_valid = 1'b0;
        chk("drop_addr_held", 64'(mem_addr), 64'h8);
        n = 0;
        while (mem_req && mem_addr == 32'h8 && n < 10) begin
            chk("drop_id_valid", 64'(id_valid), 64'd0);
            step(); n++;
        end
        chk("drop_next_req", 64'(mem_req), 64'd1);
        chk("drop_next_addr", 64'(mem_addr), 64'h40);
        n = 0;
        while (!id_valid && n < 10) begin step(); n++; end
        chk("drop_first_pc", 64'(id_pc), 64'h40);

        // Redirect coincident with ack and pop.
        waits = 0;
        do_reset();
        n = 0;
        while (!id_valid && n < 5) begin step(); n++; end
        chk("coinc_pre_req", 64'(mem_req), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("coinc_empty", 64'(id_valid), 64'd0);
        chk("coinc_addr", 64'(mem_addr), 64'h100);
        step();
        chk("coinc_pc", 64'(id_pc), 64'h100);
        chk("coinc_inst", 64'(id_inst), 64'(ram(32'h100)));

        // Asynchronous reset between edges.
        waits = 3;
        do_reset();
        n = 0;
        while (!mem_req && n < 3) begin step(); n++; end
        #2;
        rst = 1'b0;
        #1;
        chk("async_mem_req", 64'(mem_req), 64'd0);
        chk("async_id_valid", 64'(id_valid), 64'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("async_restart_req", 64'(mem_req), 64'd1);
        chk("async_restart_addr", 64'(mem_addr), 64'd0);

        // Randomized traffic against the model.
        rand_w = 1;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
